dut_req_arbiter: RTL and testbench
==================================

Name: dut_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single DUT port among NUM_REQ transaction sources (generator/driver channels).
- Sits between the per-channel drivers and the DUT port of the interface.
- Accepts one request at a time and presents it to the DUT with a valid/ready handshake.
- Waits for the DUT's completion pulse, then returns a one-cycle response strobe to the requester that owns the transaction.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, payload width per request.
- TIMEOUT, 64, watchdog limit in cycles for the WAIT state (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_data  in  NUM_REQ*DATA_W  packed payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept, combinational.
- dut_valid  out  1  transaction valid toward the DUT.
- dut_data  out  DATA_W  latched payload.
- dut_ready  in  1  DUT accepts the transaction.
- dut_done  in  1  DUT completion pulse.
- rsp_valid  out  NUM_REQ  one-cycle completion strobe to the owning requester.
- grant_id  out  $clog2(NUM_REQ)  current or last owner index.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first).
  - dut_valid=0, dut_data=0, rsp_valid=0, grant_id=0, busy=0.
  - req_ready is combinational and therefore 0 while reset is high.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Winner = the first asserted req_valid, searching from index last_grant+1 upward modulo NUM_REQ.
  - req_ready[winner]=1 combinationally; all other req_ready bits are 0.
  - On the accept edge:
    - latch req_data slice into dut_data;
    - grant_id<=winner, last_grant<=winner;
    - go to ISSUE.
  - With no req_valid asserted, stay in IDLE with req_ready=0.
- ISSUE:
  - dut_valid=1; dut_data is held stable until dut_ready is seen.
  - dut_ready=1 and dut_done=0: go to WAIT, dut_valid<=0.
  - dut_ready=1 and dut_done=1 in the same cycle: skip WAIT; pulse rsp_valid[grant_id] next cycle; go to IDLE.
- WAIT:
  - dut_done=1: rsp_valid[grant_id]=1 for exactly one cycle; go to IDLE.
  - dut_done is ignored in IDLE and ISSUE, apart from the simultaneous case above.
- Latency:
  - Accept edge = cycle 0.
  - dut_valid is first high in cycle 1.
  - rsp_valid is high in the cycle after the dut_done edge.
  - No new request is accepted in the cycle rsp_valid is high; arbitration resumes the following cycle.
- req_ready is 0 in ISSUE and WAIT; requesters hold their req_valid.
- Fairness: a requester asserting continuously is served at least once every NUM_REQ transactions.
- Wrap-around: last_grant=NUM_REQ-1 continues the search at index 0.
- Reset mid-operation:
  - the in-flight transaction is dropped and no rsp_valid is produced;
  - the arbiter returns to IDLE with requester 0 at highest priority.

Optional Feature:
- Macro: DUT_ARB_TIMEOUT_EN.
- With the macro defined:
  - adds output timeout_err (1 bit, reset 0) and a WAIT-state cycle counter of $clog2(TIMEOUT+1) bits, cleared on entry to WAIT;
  - if the counter reaches TIMEOUT without dut_done:
    - timeout_err pulses for one cycle;
    - rsp_valid[grant_id] pulses in the same cycle;
    - FSM returns to IDLE.
- Without the macro: no port and no counter; WAIT lasts indefinitely until dut_done.

Decomposition:
- Package dut_arb_pkg holds:
  - the state enum typedef (IDLE, ISSUE, WAIT);
  - default parameter constants;
  - a function that returns the round-robin winner index given the request vector and last_grant.
- One sub-module is natural: rr_pick, combinational. Inputs are req vector and last_grant; outputs are winner index and an any flag. It is instantiated once.

Test Plan:
- Single request, requester 2, data 0xDEADBEEF, dut_ready immediate, dut_done 3 cycles later:
  - req_ready[2] high in cycle 0;
  - dut_valid with 0xDEADBEEF in cycle 1;
  - rsp_valid=4'b0100 one cycle after dut_done.
- All 4 requesters valid continuously, 8 transactions: grant order 0,1,2,3,0,1,2,3.
- dut_ready held low 5 cycles in ISSUE:
  - dut_valid and dut_data stay stable for all 5 cycles;
  - req_ready stays 0 throughout.
- dut_ready and dut_done asserted in the same cycle: busy drops and rsp_valid pulses on the next cycle, with no WAIT cycle.
- Reset asserted during WAIT:
  - outputs clear immediately (async);
  - no rsp_valid is produced;
  - after release with requesters 0 and 3 valid, requester 0 is granted.
- With DUT_ARB_TIMEOUT_EN defined and TIMEOUT=8, no dut_done: timeout_err and rsp_valid pulse together 8 cycles after WAIT entry, then the FSM is back in IDLE.

Source files
------------

// File: rtl/dut_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dut_arb_pkg
// Purpose  : Shared types and helpers for the dut_req_arbiter block.
//            - arb_state_t : FSM state encoding (IDLE, ISSUE, WAIT)
//            - default parameter constants
//            - rr_winner() : round-robin winner search
// Ports    : none (package)
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
package dut_arb_pkg;

    localparam int c_num_req_def = 4;
    localparam int c_data_w_def  = 32;
    localparam int c_timeout_def = 64;

    // Widest configuration the helper below is sized for.
    localparam int c_max_req     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    // Round-robin search: first set bit of req starting at last+1 and
    // wrapping modulo n. Callers zero-extend narrower vectors into the
    // 8-bit argument; n must be in 2..8. Returns 0 when nothing is set,
    // so callers must qualify the result with |req.
    function automatic logic [2:0] rr_winner(
        input logic [7:0] req,
        input logic [2:0] last,
        input int         n
    );
        logic [2:0] win;
        logic       found;
        int         j;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= c_max_req; k++) begin
            j = (int'(last) + k) % n;
            if (!found && (k <= n) && req[3'(j)]) begin
                win   = 3'(j);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage : dut_arb_pkg
`default_nettype wire

// File: rtl/dut_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface: dut_req_arbiter_if
// Purpose  : Bundles the requester-side and DUT-side handshake signals of
//            the arbiter.
//            master : the arbiter's view (drives req_ready, dut_*, rsp_*)
//            slave  : the environment's view (requesters + DUT)
// Ports    : req_valid/req_data/req_ready, dut_valid/dut_data/dut_ready/
//            dut_done, rsp_valid, grant_id, busy
//            [+ timeout_err when DUT_ARB_TIMEOUT_EN is defined]
// Options  : DUT_ARB_TIMEOUT_EN adds timeout_err
// Revision : 1.0 - initial release
// ============================================================================
interface dut_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) ();

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       dut_valid;
    logic [DATA_W-1:0]          dut_data;
    logic                       dut_ready;
    logic                       dut_done;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [$clog2(NUM_REQ)-1:0] grant_id;
    logic                       busy;
`ifdef DUT_ARB_TIMEOUT_EN
    logic                       timeout_err;
`endif

    modport master (
        input  req_valid, req_data, dut_ready, dut_done,
        output req_ready, dut_valid, dut_data, rsp_valid, grant_id, busy
`ifdef DUT_ARB_TIMEOUT_EN
        , output timeout_err
`endif
    );

    modport slave (
        output req_valid, req_data, dut_ready, dut_done,
        input  req_ready, dut_valid, dut_data, rsp_valid, grant_id, busy
`ifdef DUT_ARB_TIMEOUT_EN
        , input timeout_err
`endif
    );

endinterface : dut_req_arbiter_if
`default_nettype wire

// File: rtl/dut_req_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Chooses the first asserted
//            request after i_last_grant, wrapping to index 0.
// Ports    : i_req        in  NUM_REQ  request vector
//            i_last_grant in  IDX_W    index granted most recently
//            o_winner     out IDX_W    winning index (valid when o_any)
//            o_any        out 1        at least one request asserted
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import dut_arb_pkg::*;
#(
    parameter int NUM_REQ = c_num_req_def,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any
);

    assign o_winner = IDX_W'(rr_winner(8'(i_req), 3'(i_last_grant), NUM_REQ));
    assign o_any    = |i_req;

endmodule : rr_pick
`default_nettype wire

// File: rtl/dut_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dut_req_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one DUT port among
//            NUM_REQ requesters. One transaction in flight at a time:
//            IDLE (arbitrate/accept) -> ISSUE (valid/ready to DUT)
//            -> WAIT (for dut_done) -> one-cycle rsp_valid to the owner.
// Ports    : clk   in  1   rising-edge clock
//            reset in  1   asynchronous, active-high reset
//            bus   master modport of dut_req_arbiter_if (req_*, dut_*,
//                  rsp_valid, grant_id, busy [, timeout_err])
// Options  : DUT_ARB_TIMEOUT_EN - WAIT-state watchdog of TIMEOUT cycles;
//            on expiry timeout_err and rsp_valid pulse together.
// Revision : 1.0 - initial release
// ============================================================================
module dut_req_arbiter
    import dut_arb_pkg::*;
#(
    parameter int NUM_REQ = c_num_req_def,
    parameter int DATA_W  = c_data_w_def,
    parameter int TIMEOUT = c_timeout_def
) (
    input  logic              clk,
    input  logic              reset,
    dut_req_arbiter_if.master bus
);

    localparam int c_idx_w = $clog2(NUM_REQ);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;

    logic [c_idx_w-1:0] r_last_grant;
    logic [c_idx_w-1:0] r_grant_id;
    logic [DATA_W-1:0]  r_dut_data;
    logic [NUM_REQ-1:0] r_rsp_valid;

    logic [c_idx_w-1:0] w_winner;
    logic               w_any;
    logic               w_accept;
    logic               w_rsp_fire;
    logic               w_timeout;
    logic [NUM_REQ-1:0] w_win_onehot;
    logic [DATA_W-1:0]  w_slice [NUM_REQ];

    // Supported range is NUM_REQ 2..8 and TIMEOUT >= 1; this block only
    // elaborates for an unsupported configuration and marks it.
    if (NUM_REQ < 2 || NUM_REQ > c_max_req || TIMEOUT < 1) begin : g_unsupported_config
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_slice[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_rr_pick (
        .i_req        (bus.req_valid),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_any        (w_any)
    );

    assign w_win_onehot = NUM_REQ'(1) << w_winner;

`ifdef DUT_ARB_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);

    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               r_timeout_err;

    // Fires on the edge that would take the counter to TIMEOUT; a
    // coincident dut_done wins and is treated as a normal completion.
    assign w_timeout = (r_state == WAIT) && !bus.dut_done &&
                       (r_wait_cnt == c_cnt_w'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (r_state == ISSUE && w_state_nxt == WAIT) begin
                r_wait_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    assign bus.timeout_err = r_timeout_err;
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rsp_fire  = 1'b0;
        case (r_state)
            IDLE: begin
                // The cycle carrying rsp_valid is a dead cycle for
                // arbitration; reset also masks the combinational accept.
                if (w_any && (r_rsp_valid == '0) && !reset) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.dut_ready) begin
                    if (bus.dut_done) begin
                        w_rsp_fire  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.dut_done || w_timeout) begin
                    w_rsp_fire  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // last_grant = NUM_REQ-1 puts requester 0 first in line.
            r_last_grant <= c_idx_w'(NUM_REQ - 1);
            r_grant_id   <= '0;
            r_dut_data   <= '0;
            r_rsp_valid  <= '0;
        end else begin
            r_rsp_valid <= w_rsp_fire ? (NUM_REQ'(1) << r_grant_id) : '0;
            if (w_accept) begin
                r_dut_data   <= w_slice[w_winner];
                r_grant_id   <= w_winner;
                r_last_grant <= w_winner;
            end
        end
    end

    assign bus.req_ready = w_accept ? w_win_onehot : '0;
    assign bus.dut_valid = (r_state == ISSUE);
    assign bus.dut_data  = r_dut_data;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.grant_id  = r_grant_id;
    assign bus.busy      = (r_state != IDLE);

endmodule : dut_req_arbiter
`default_nettype wire

// File: tb/tb_dut_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dut_req_arbiter
// Purpose  : Directed self-checking bench for dut_req_arbiter (NUM_REQ=4,
//            DATA_W=32, TIMEOUT=8). Cycle numbering: the accept edge ends
//            cycle 0. Inputs change and outputs are sampled 1 ns after
//            each rising edge.
// Ports    : none
// Options  : DUT_ARB_TIMEOUT_EN selects the watchdog scenario
// Revision : 1.0 - initial release
// ============================================================================
module tb_dut_req_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    dut_req_arbiter_if #(.NUM_REQ(4), .DATA_W(32)) bus ();

    dut_req_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_data  = '0;
        bus.dut_ready = 1'b0;
        bus.dut_done  = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
        tick();
        checks++; if (bus.dut_valid !== 1'b0) begin failures++; $display("FAIL reset_dut_valid got=%b exp=0", bus.dut_valid); end
        checks++; if (bus.dut_data !== 32'h0) begin failures++; $display("FAIL reset_dut_data got=%h exp=0", bus.dut_data); end
        checks++; if (bus.rsp_valid !== 4'b0000) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0000", bus.rsp_valid); end
        checks++; if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id got=%0d exp=0", bus.grant_id); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
`ifdef DUT_ARB_TIMEOUT_EN
        checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got=%b exp=0", bus.timeout_err); end
`endif
        bus.req_valid = 4'b0000;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_oh;
        int         exp_id;
        for (int i = 0; i < 4; i++) bus.req_data[i*32 +: 32] = 32'h100 + i;
        bus.req_valid = 4'b1111;
        bus.dut_ready = 1'b1;
        bus.dut_done  = 1'b0;
        for (int t = 0; t < 8; t++) begin
            exp_id = t % 4;
            exp_oh = 4'b0001 << exp_id;
            #1;
            checks++; if (bus.req_ready !== exp_oh) begin failures++; $display("FAIL rr_req_ready txn=%0d got=%b exp=%b", t, bus.req_ready, exp_oh); end
            tick();
            checks++; if (bus.grant_id !== 2'(exp_id)) begin failures++; $display("FAIL rr_grant_id txn=%0d got=%0d exp=%0d", t, bus.grant_id, exp_id); end
            checks++; if (bus.dut_data !== 32'h100 + 32'(exp_id)) begin failures++; $display("FAIL rr_dut_data txn=%0d got=%h exp=%h", t, bus.dut_data, 32'h100 + 32'(exp_id)); end
            tick();
            bus.dut_done = 1'b1;
            tick();
            bus.dut_done = 1'b0;
            checks++; if (bus.rsp_valid !== exp_oh) begin failures++; $display("FAIL rr_rsp_valid txn=%0d got=%b exp=%b", t, bus.rsp_valid, exp_oh); end
            #1;
            checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL rr_no_accept_in_rsp txn=%0d got=%b exp=0000", t, bus.req_ready); end
            tick();
        end
        bus.req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_single_req();
        bus.req_data[2*32 +: 32] = 32'hDEADBEEF;
        bus.req_valid = 4'b0100;
        bus.dut_ready = 1'b1;
        bus.dut_done  = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL single_req_ready got=%b exp=0100", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        checks++; if (bus.dut_valid !== 1'b1) begin failures++; $display("FAIL single_dut_valid got=%b exp=1", bus.dut_valid); end
        checks++; if (bus.dut_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_dut_data got=%h exp=deadbeef", bus.dut_data); end
        checks++; if (bus.grant_id !== 2'd2) begin failures++; $display("FAIL single_grant_id got=%0d exp=2", bus.grant_id); end
        tick();
        checks++; if (bus.dut_valid !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL single_wait_state got valid=%b busy=%b exp valid=0 busy=1", bus.dut_valid, bus.busy); end
        tick();
        tick();
        bus.dut_done = 1'b1;
        #1;
        checks++; if (bus.rsp_valid !== 4'b0000) begin failures++; $display("FAIL single_rsp_early got=%b exp=0000", bus.rsp_valid); end
        tick();
        bus.dut_done = 1'b0;
        checks++; if (bus.rsp_valid !== 4'b0100 || bus.busy !== 1'b0) begin failures++; $display("FAIL single_rsp got rsp=%b busy=%b exp rsp=0100 busy=0", bus.rsp_valid, bus.busy); end
        tick();
        checks++; if (bus.rsp_valid !== 4'b0000) begin failures++; $display("FAIL single_rsp_one_cycle got=%b exp=0000", bus.rsp_valid); end
    endtask

    // last_grant=2 on entry, so requester 0 beats requester 1.
    task automatic test_issue_stall();
        bus.req_data[0*32 +: 32] = 32'hA5A50000;
        bus.req_data[1*32 +: 32] = 32'hA5A50001;
        bus.req_valid = 4'b0011;
        bus.dut_ready = 1'b0;
        bus.dut_done  = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL stall_req_ready got=%b exp=0001", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0010;
        bus.req_data[0*32 +: 32] = 32'hFFFFFFFF;
        for (int c = 0; c < 5; c++) begin
            // A stray dut_done during ISSUE without dut_ready is ignored.
            bus.dut_done = (c == 2);
            #1;
            checks++; if (bus.dut_valid !== 1'b1 || bus.dut_data !== 32'hA5A50000) begin failures++; $display("FAIL stall_hold cyc=%0d got valid=%b data=%h exp valid=1 data=a5a50000", c, bus.dut_valid, bus.dut_data); end
            checks++; if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 4'b0000) begin failures++; $display("FAIL stall_quiet cyc=%0d got ready=%b rsp=%b exp 0000/0000", c, bus.req_ready, bus.rsp_valid); end
            tick();
        end
        bus.dut_done  = 1'b0;
        bus.dut_ready = 1'b1;
        tick();
        checks++; if (bus.dut_valid !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL stall_to_wait got valid=%b busy=%b exp 0/1", bus.dut_valid, bus.busy); end
        bus.dut_done = 1'b1;
        tick();
        bus.dut_done = 1'b0;
        checks++; if (bus.rsp_valid !== 4'b0001) begin failures++; $display("FAIL stall_rsp got=%b exp=0001", bus.rsp_valid); end
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL stall_rsp_cycle_ready got=%b exp=0000", bus.req_ready); end
        tick();
        checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL stall_next_ready got=%b exp=0010", bus.req_ready); end
    endtask

    // Continues from test_issue_stall: requester 1 is being accepted.
    task automatic test_ready_done_same_cycle();
        bus.dut_ready = 1'b1;
        bus.dut_done  = 1'b0;
        tick();
        bus.req_valid = 4'b0000;
        bus.dut_done  = 1'b1;
        checks++; if (bus.dut_valid !== 1'b1 || bus.dut_data !== 32'hA5A50001) begin failures++; $display("FAIL same_issue got valid=%b data=%h exp 1/a5a50001", bus.dut_valid, bus.dut_data); end
        tick();
        bus.dut_done = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0010) begin failures++; $display("FAIL same_rsp got busy=%b rsp=%b exp 0/0010", bus.busy, bus.rsp_valid); end
        tick();
        checks++; if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0) begin failures++; $display("FAIL same_after got rsp=%b busy=%b exp 0000/0", bus.rsp_valid, bus.busy); end
    endtask

    task automatic test_reset_in_wait();
        bus.req_data[2*32 +: 32] = 32'h22222222;
        bus.req_data[0*32 +: 32] = 32'h00C0FFEE;
        bus.req_data[3*32 +: 32] = 32'h33333333;
        bus.req_valid = 4'b0100;
        bus.dut_ready = 1'b1;
        bus.dut_done  = 1'b0;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        checks++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'd2) begin failures++; $display("FAIL rstw_in_wait got busy=%b id=%0d exp 1/2", bus.busy, bus.grant_id); end
        reset = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.grant_id !== 2'd0 || bus.dut_data !== 32'h0) begin failures++; $display("FAIL rstw_async_clear got busy=%b id=%0d data=%h exp 0/0/0", bus.busy, bus.grant_id, bus.dut_data); end
        bus.dut_done  = 1'b1;
        bus.req_valid = 4'b1001;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL rstw_ready_in_reset got=%b exp=0000", bus.req_ready); end
        tick();
        tick();
        reset        = 1'b0;
        bus.dut_done = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b0001 || bus.rsp_valid !== 4'b0000) begin failures++; $display("FAIL rstw_priority got ready=%b rsp=%b exp 0001/0000", bus.req_ready, bus.rsp_valid); end
        tick();
        bus.req_valid = 4'b0000;
        checks++; if (bus.dut_data !== 32'h00C0FFEE || bus.rsp_valid !== 4'b0000) begin failures++; $display("FAIL rstw_grant got data=%h rsp=%b exp 00c0ffee/0000", bus.dut_data, bus.rsp_valid); end
        tick();
        bus.dut_done = 1'b1;
        tick();
        bus.dut_done = 1'b0;
        checks++; if (bus.rsp_valid !== 4'b0001) begin failures++; $display("FAIL rstw_rsp got=%b exp=0001", bus.rsp_valid); end
        tick();
    endtask

`ifdef DUT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bus.req_data[2*32 +: 32] = 32'h77777777;
        bus.req_valid = 4'b0100;
        bus.dut_ready = 1'b1;
        bus.dut_done  = 1'b0;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        for (int c = 0; c < 8; c++) begin
            checks++; if (bus.busy !== 1'b1 || bus.timeout_err !== 1'b0 || bus.rsp_valid !== 4'b0000) begin failures++; $display("FAIL to_waiting cyc=%0d got busy=%b err=%b rsp=%b exp 1/0/0000", c, bus.busy, bus.timeout_err, bus.rsp_valid); end
            tick();
        end
        checks++; if (bus.timeout_err !== 1'b1 || bus.rsp_valid !== 4'b0100 || bus.busy !== 1'b0) begin failures++; $display("FAIL to_expire got err=%b rsp=%b busy=%b exp 1/0100/0", bus.timeout_err, bus.rsp_valid, bus.busy); end
        tick();
        checks++; if (bus.timeout_err !== 1'b0 || bus.rsp_valid !== 4'b0000) begin failures++; $display("FAIL to_pulse_end got err=%b rsp=%b exp 0/0000", bus.timeout_err, bus.rsp_valid); end
    endtask
`else
    task automatic test_long_wait();
        bus.req_data[2*32 +: 32] = 32'h77777777;
        bus.req_valid = 4'b0100;
        bus.dut_ready = 1'b1;
        bus.dut_done  = 1'b0;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        for (int c = 0; c < 12; c++) begin
            checks++; if (bus.busy !== 1'b1 || bus.rsp_valid !== 4'b0000) begin failures++; $display("FAIL lw_waiting cyc=%0d got busy=%b rsp=%b exp 1/0000", c, bus.busy, bus.rsp_valid); end
            tick();
        end
        bus.dut_done = 1'b1;
        tick();
        bus.dut_done = 1'b0;
        checks++; if (bus.rsp_valid !== 4'b0100 || bus.busy !== 1'b0) begin failures++; $display("FAIL lw_rsp got rsp=%b busy=%b exp 0100/0", bus.rsp_valid, bus.busy); end
        tick();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_round_robin();
        test_single_req();
        test_issue_stall();
        test_ready_done_same_cycle();
        test_reset_in_wait();
`ifdef DUT_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dut_req_arbiter
`default_nettype wire
